// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register bridge: FSM encoding, command byte layout, reset byte.
package spi_reg_pkg;

  // FSM state encoding
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCmd  = 3'd1;
  localparam logic [2:0] StWr   = 3'd2;
  localparam logic [2:0] StRd   = 3'd3;
  localparam logic [2:0] StDrop = 3'd4;

  // Command byte layout: bit 7 selects write, bits [6:0] carry the start address
  localparam int unsigned CMD_WR_BIT   = 7;
  localparam int unsigned CMD_ADDR_MSB = 6;

  // Value driven on tx_byte when idle, after an abort, or for an illegal address
  localparam logic [7:0] RESET_BYTE = 8'h00;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with a configurable reset value.
module spi_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; first stage may go metastable, second is clean
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Maps SPI byte frames onto a bank of 8-bit registers with auto-incrementing burst access.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_cs,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_dv,
  output logic [NREG*8-1:0] reg_q,
  output logic              wr_stb,
  output logic [6:0]        wr_addr
);

  logic              cs_sync;
  logic              cs_prev_q;
  logic [1:0]        cs_live_q;
  logic [2:0]        state_q;
  logic [6:0]        ptr_q;
  logic [NREG*8-1:0] regs_q;
  logic [7:0]        tx_byte_q;
  logic              tx_dv_q;
  logic              wr_stb_q;
  logic [6:0]        wr_addr_q;

  logic              frame_start;
  logic              frame_end;
  logic              addr_ok;
  logic              wr_en;
  logic [6:0]        ptr_inc;
  logic [6:0]        rd_idx;
  logic [7:0]        rd_data;

  spi_sync2 #(
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (spi_cs),
    .q_o    (cs_sync)
  );

  // Edge detector; cs_prev_q is held low until the synchroniser output reflects real input,
  // so a CS already low when reset releases is not mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs_live_q <= 2'b00;
      cs_prev_q <= 1'b0;
    end else begin
      cs_live_q <= {cs_live_q[0], 1'b1};
      cs_prev_q <= cs_sync & cs_live_q[1];
    end
  end

  assign frame_start = cs_prev_q & ~cs_sync;
  assign frame_end   = cs_sync;

  // Pointer increment with wrap, and the register read mux feeding tx_byte
  always_comb begin
    ptr_inc = (ptr_q == 7'(NREG - 1)) ? 7'd0 : ptr_q + 7'd1;
    rd_idx  = (state_q == StCmd) ? rx_byte[CMD_ADDR_MSB:0] : ptr_inc;
    addr_ok = {1'b0, rx_byte[CMD_ADDR_MSB:0]} < 8'(NREG);
    wr_en   = rx_dv & ~frame_end & ~frame_start & (state_q == StWr);
    rd_data = 8'h00;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rd_idx == 7'(i)) rd_data = regs_q[8*i +: 8];
    end
  end

  // Register storage; only the WR state writes, at the current pointer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      regs_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (ptr_q == 7'(i)) regs_q[8*i +: 8] <= rx_byte;
      end
    end
  end

  // Frame FSM: frame end beats frame start beats received bytes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      ptr_q     <= 7'd0;
      tx_byte_q <= RESET_BYTE;
      tx_dv_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
    end else begin
      tx_dv_q  <= 1'b0;
      wr_stb_q <= 1'b0;
      if (frame_end) begin
        state_q <= StIdle;
        if (state_q != StIdle) tx_byte_q <= RESET_BYTE;
      end else if (frame_start) begin
        state_q   <= StCmd;
        tx_byte_q <= ID_BYTE;
        tx_dv_q   <= 1'b1;
      end else if (rx_dv) begin
        case (state_q)
          StCmd: begin
            ptr_q <= rx_byte[CMD_ADDR_MSB:0];
            if (!addr_ok) begin
              state_q   <= StDrop;
              tx_byte_q <= RESET_BYTE;
              tx_dv_q   <= 1'b1;
            end else if (rx_byte[CMD_WR_BIT]) begin
              state_q <= StWr;
            end else begin
              state_q   <= StRd;
              tx_byte_q <= rd_data;
              tx_dv_q   <= 1'b1;
            end
          end
          StWr: begin
            wr_stb_q  <= 1'b1;
            wr_addr_q <= ptr_q;
            ptr_q     <= ptr_inc;
          end
          StRd: begin
            ptr_q     <= ptr_inc;
            tx_byte_q <= rd_data;
            tx_dv_q   <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tx_byte = tx_byte_q;
  assign tx_dv   = tx_dv_q;
  assign reg_q   = regs_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected tx bytes and register writes are queued
// as stimulus is driven and checked as the DUT pulses tx_dv / wr_stb.
module tb_spi_reg_bridge;

  localparam int unsigned NREG = 16;

  logic            clk;
  logic            resetn;
  logic            spi_cs;
  logic            rx_dv;
  logic [7:0]      rx_byte;
  logic [7:0]      tx_byte;
  logic            tx_dv;
  logic [NREG*8-1:0] reg_q;
  logic            wr_stb;
  logic [6:0]      wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_tx[$];
  logic [14:0] exp_wr[$];
  logic [7:0]  model[NREG];

  spi_reg_bridge #(
    .NREG    (NREG),
    .ID_BYTE (8'hA5)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .spi_cs  (spi_cs),
    .rx_dv   (rx_dv),
    .rx_byte (rx_byte),
    .tx_byte (tx_byte),
    .tx_dv   (tx_dv),
    .reg_q   (reg_q),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] model_packed();
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < int'(NREG); i++) p[8*i +: 8] = model[i];
    return p;
  endfunction

  // Scoreboard: every tx_dv / wr_stb pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      if (exp_tx.size() == 0) begin
        check_eq("tx_unexpected", 1, 0);
      end else begin
        check_eq("tx_byte", tx_byte, exp_tx.pop_front());
      end
    end
    if (wr_stb === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check_eq("wr_unexpected", 1, 0);
      end else begin
        logic [14:0] e;
        e = exp_wr.pop_front();
        check_eq("wr_addr", wr_addr, e[14:8]);
        check_eq("wr_data", reg_q[int'(e[14:8])*8 +: 8], e[7:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic want_tx);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    check_eq("tx_dv_latency", tx_dv, want_tx);
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    exp_tx.push_back(8'hA5);
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr_data(input logic [6:0] a, input logic [7:0] d);
    model[int'(a)] = d;
    exp_wr.push_back({a, d});
    send(d, 1'b0);
  endtask

  task automatic rd_cmd(input logic [6:0] a);
    exp_tx.push_back(model[int'(a)]);
    send({1'b0, a}, 1'b1);
  endtask

  task automatic rd_next(input logic [6:0] a);
    exp_tx.push_back(model[int'(a)]);
    send(8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NREG); i++) model[i] = 8'h00;
    resetn  = 1'b0;
    spi_cs  = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_reg_q", reg_q, '0);
    check_eq("rst_tx_byte", tx_byte, 8'h00);
    check_eq("rst_tx_dv", tx_dv, 0);
    check_eq("rst_wr_stb", wr_stb, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Write burst to reg2, reg3
    cs_low();
    send(8'h82, 1'b0);
    wr_data(7'd2, 8'h11);
    wr_data(7'd3, 8'h22);
    cs_high();
    check_eq("idle_tx_byte", tx_byte, 8'h00);

    // Read burst from reg2
    cs_low();
    rd_cmd(7'd2);
    rd_next(7'd3);
    rd_next(7'd4);
    cs_high();

    // Write wrap 15 -> 0 -> 1
    cs_low();
    send(8'h8F, 1'b0);
    wr_data(7'd15, 8'hAA);
    wr_data(7'd0, 8'hBB);
    wr_data(7'd1, 8'hCC);
    cs_high();
    check_eq("wrap_reg15", reg_q[127:120], 8'hAA);
    check_eq("wrap_reg0", reg_q[7:0], 8'hBB);
    check_eq("wrap_reg1", reg_q[15:8], 8'hCC);

    // Read wrap 15 -> 0 -> 1
    cs_low();
    rd_cmd(7'd15);
    rd_next(7'd0);
    rd_next(7'd1);
    cs_high();

    // Illegal address is dropped
    cs_low();
    exp_tx.push_back(8'h00);
    send(8'h94, 1'b1);
    send(8'hFF, 1'b0);
    check_eq("drop_tx_byte", tx_byte, 8'h00);
    cs_high();
    check_eq("drop_regs", reg_q, model_packed());

    // Abort mid-write keeps written data, fresh frame returns ID byte
    cs_low();
    send(8'h83, 1'b0);
    wr_data(7'd3, 8'h5A);
    cs_high();
    check_eq("abort_tx_byte", tx_byte, 8'h00);
    cs_low();
    check_eq("restart_tx_byte", tx_byte, 8'hA5);
    rd_cmd(7'd3);
    cs_high();

    // Reset mid-write; CS stays low so bytes must be ignored until a new fall
    cs_low();
    send(8'h85, 1'b0);
    wr_data(7'd5, 8'h77);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < int'(NREG); i++) model[i] = 8'h00;
    check_eq("midrst_reg_q", reg_q, '0);
    check_eq("midrst_tx_byte", tx_byte, 8'h00);
    repeat (4) @(negedge clk);
    send(8'h81, 1'b0);
    send(8'h55, 1'b0);
    check_eq("postrst_ignored", reg_q, '0);
    cs_high();
    cs_low();
    send(8'h81, 1'b0);
    wr_data(7'd1, 8'h55);
    cs_high();

    check_eq("final_regs", reg_q, model_packed());
    check_eq("tx_queue_drained", exp_tx.size(), 0);
    check_eq("wr_queue_drained", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
